// File: rtl/system_pkg.sv
// rtl/system_pkg.sv - shared ALU opcodes, bus FSM states and flag bit indices
// Purpose: constants shared by system_datapath and mem_bus_ctrl.
// Ports: none (package).
package system_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_SHR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2
  } bus_state_e;

  // flags port layout is {C,N,P,Z}
  localparam int FLAG_Z = 0;
  localparam int FLAG_P = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 3;

endpackage

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - memory bus handshake FSM with wait timeout
// Purpose: sequences one read or write transfer, bounded by TIMEOUT wait cycles.
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_rd_start, i_wr_start  transfer requests (sampled only in IDLE)
//   i_mem_ack               transfer complete from memory
//   o_busy, o_mem_req       high in either WAIT state
//   o_mem_we                high only in WR_WAIT
//   o_done                  one-cycle pulse after ack or timeout
//   o_bus_err               sticky timeout flag, cleared on next start
//   o_rd_load               MDR load strobe for read data (same edge as ack)
module mem_bus_ctrl
  import system_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rd_start,
  input  logic i_wr_start,
  input  logic i_mem_ack,
  output logic o_busy,
  output logic o_mem_req,
  output logic o_mem_we,
  output logic o_done,
  output logic o_bus_err,
  output logic o_rd_load
);

  localparam int CW = $clog2(TIMEOUT + 1);

  bus_state_e     r_state;
  bus_state_e     w_next;
  logic [CW-1:0]  r_cnt;
  logic           r_done;
  logic           r_bus_err;
  logic           w_wait;
  logic           w_ack;
  logic           w_timeout;
  logic           w_start;

  assign w_wait    = (r_state != ST_IDLE);
  assign w_ack     = w_wait && i_mem_ack;
  // ack has priority: timeout only fires when ack is absent on the final wait cycle
  assign w_timeout = w_wait && !i_mem_ack && (r_cnt == CW'(TIMEOUT - 1));
  assign w_start   = !w_wait && (i_rd_start || i_wr_start);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_rd_start) begin
          w_next = ST_RD_WAIT;
        end else if (i_wr_start) begin
          w_next = ST_WR_WAIT;
        end
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        if (w_ack || w_timeout) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_done <= w_ack || w_timeout;
      if (w_start) begin
        r_cnt     <= '0;
        r_bus_err <= 1'b0;
      end else begin
        if (w_wait && !w_timeout) begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_timeout) begin
          r_bus_err <= 1'b1;
        end
      end
    end
  end

  assign o_busy    = w_wait;
  assign o_mem_req = w_wait;
  assign o_mem_we  = (r_state == ST_WR_WAIT);
  assign o_done    = r_done;
  assign o_bus_err = r_bus_err;
  assign o_rd_load = w_ack && (r_state == ST_RD_WAIT);

endmodule

// File: rtl/system_datapath.sv
// rtl/system_datapath.sv - accumulator datapath with ALU, register bank, IR/MAR/MDR and memory bus
// Purpose: busA = r0, busB = bank[busb_addr], busC = MDR; ALU feeds MDR or memory read data does.
// Ports:
//   clk, rst                       clock, async active-low reset
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack   memory bus
//   rd_start, wr_start, busy, done, bus_err               transfer control/status
//   enaf, selop, shamt, flags      ALU control and {C,N,P,Z}
//   bank_wr_en, busb_addr, busc_addr   register bank access
//   ir_en, mar_en, mdr_en, sclr, mdr_alu_n   register loads
//   out_ir                         IR opcode field
module system_datapath
  import system_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int OPCODE_WIDTH   = 5,
  parameter int TIMEOUT        = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_ack,
  input  logic                      rd_start,
  input  logic                      wr_start,
  output logic                      busy,
  output logic                      done,
  output logic                      bus_err,
  input  logic                      enaf,
  input  logic [2:0]                selop,
  input  logic [1:0]                shamt,
  output logic [3:0]                flags,
  input  logic                      bank_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] busb_addr,
  input  logic [REG_ADDR_WIDTH-1:0] busc_addr,
  input  logic                      ir_en,
  input  logic                      mar_en,
  input  logic                      mdr_en,
  input  logic                      sclr,
  input  logic                      mdr_alu_n,
  output logic [OPCODE_WIDTH-1:0]   out_ir
);

  localparam int DW   = DATA_WIDTH;
  localparam int NREG = 2 ** REG_ADDR_WIDTH;

  logic [DW-1:0]             r_bank [NREG];
  logic [DW-1:0]             r_ir;
  logic [MEM_ADDR_WIDTH-1:0] r_mar;
  logic [DW-1:0]             r_mdr;
  logic [3:0]                r_flags;

  logic [DW-1:0] w_busa;
  logic [DW-1:0] w_busb;
  logic [DW-1:0] w_busc;
  logic [DW:0]   w_sum;
  logic [DW:0]   w_dif;
  logic [DW:0]   w_shl;
  logic [DW:0]   w_shr;
  logic [DW-1:0] w_res;
  logic          w_c;
  logic          w_busy;
  logic          w_rd_load;

  assign w_busa = r_bank[0];
  assign w_busb = r_bank[busb_addr];
  assign w_busc = r_mdr;

  // Register bank holds no reset so it survives a bus reset.
  always_ff @(posedge clk) begin
    if (bank_wr_en) begin
      r_bank[busc_addr] <= w_busc;
    end
  end

  // Extra bit carries carry/borrow; shifts widen so the last bit out lands in it.
  assign w_sum = {1'b0, w_busa} + {1'b0, w_busb};
  assign w_dif = {1'b0, w_busa} - {1'b0, w_busb};
  assign w_shl = {1'b0, w_busa} << shamt;
  assign w_shr = {w_busa, 1'b0} >> shamt;

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    case (selop)
      ALU_ADD: begin w_res = w_sum[DW-1:0]; w_c = w_sum[DW]; end
      ALU_SUB: begin w_res = w_dif[DW-1:0]; w_c = w_dif[DW]; end
      ALU_AND: w_res = w_busa & w_busb;
      ALU_OR:  w_res = w_busa | w_busb;
      ALU_XOR: w_res = w_busa ^ w_busb;
      ALU_NOT: w_res = ~w_busa;
      ALU_SHL: begin w_res = w_shl[DW-1:0]; w_c = w_shl[DW]; end
      ALU_SHR: begin w_res = w_shr[DW:1];   w_c = w_shr[0];  end
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flags <= '0;
      r_ir    <= '0;
      r_mar   <= '0;
      r_mdr   <= '0;
    end else begin
      if (enaf) begin
        r_flags[FLAG_C] <= w_c;
        r_flags[FLAG_N] <= w_res[DW-1];
        r_flags[FLAG_P] <= ~^w_res;
        r_flags[FLAG_Z] <= (w_res == '0);
      end
      if (sclr) begin
        r_ir <= '0;
      end else if (ir_en) begin
        r_ir <= w_busc;
      end
      if (mar_en) begin
        r_mar <= MEM_ADDR_WIDTH'(w_busc);
      end
      // read completion owns MDR; CPU loads are locked out during a transfer
      if (w_rd_load) begin
        r_mdr <= mem_rdata;
      end else if (mdr_en && !w_busy) begin
        r_mdr <= mdr_alu_n ? mem_rdata : w_res;
      end
    end
  end

  mem_bus_ctrl #(
    .TIMEOUT (TIMEOUT)
  ) u_bus (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_rd_start (rd_start),
    .i_wr_start (wr_start),
    .i_mem_ack  (mem_ack),
    .o_busy     (w_busy),
    .o_mem_req  (mem_req),
    .o_mem_we   (mem_we),
    .o_done     (done),
    .o_bus_err  (bus_err),
    .o_rd_load  (w_rd_load)
  );

  assign busy      = w_busy;
  assign mem_addr  = r_mar;
  assign mem_wdata = r_mdr;
  assign flags     = r_flags;
  assign out_ir    = r_ir[DW-1 -: OPCODE_WIDTH];

endmodule

// File: tb/tb_system_datapath.sv
// tb/tb_system_datapath.sv - directed and randomized checks of system_datapath
module tb_system_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mem_req, mem_we, busy, done, bus_err;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic       mem_ack = 1'b0;
  logic       rd_start = 1'b0, wr_start = 1'b0;
  logic       enaf = 1'b0;
  logic [2:0] selop = '0;
  logic [1:0] shamt = '0;
  logic [3:0] flags;
  logic       bank_wr_en = 1'b0;
  logic [2:0] busb_addr = '0, busc_addr = '0;
  logic       ir_en = 1'b0, mar_en = 1'b0, mdr_en = 1'b0, sclr = 1'b0;
  logic       mdr_alu_n = 1'b1;
  logic [4:0] out_ir;

  int errors = 0;
  int checks = 0;
  logic [3:0] model_flags = '0;

  system_datapath dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rd_start(rd_start), .wr_start(wr_start),
    .busy(busy), .done(done), .bus_err(bus_err),
    .enaf(enaf), .selop(selop), .shamt(shamt), .flags(flags),
    .bank_wr_en(bank_wr_en), .busb_addr(busb_addr), .busc_addr(busc_addr),
    .ir_en(ir_en), .mar_en(mar_en), .mdr_en(mdr_en), .sclr(sclr),
    .mdr_alu_n(mdr_alu_n), .out_ir(out_ir)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mdr(input int v);
    mem_rdata = 8'(v); mdr_alu_n = 1'b1; mdr_en = 1'b1;
    tick();
    mdr_en = 1'b0;
  endtask

  task automatic write_reg(input int addr, input int v);
    load_mdr(v);
    busc_addr = 3'(addr); bank_wr_en = 1'b1;
    tick();
    bank_wr_en = 1'b0;
  endtask

  // Reference ALU from the arithmetic definitions on 0..255 integers.
  task automatic ref_alu(input int a, input int b, input int op, input int sh,
                         output int res, output logic [3:0] fl);
    int r;
    int ones;
    bit c;
    c = 0;
    case (op)
      0: begin r = a + b; c = (r > 255); end
      1: begin r = a - b; c = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a;
      6: begin r = a << sh; c = (sh != 0) ? (((a >> (8 - sh)) & 1) != 0) : 0; end
      default: begin r = a >> sh; c = (sh != 0) ? (((a >> (sh - 1)) & 1) != 0) : 0; end
    endcase
    r = r & 255;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += (r >> i) & 1;
    res = r;
    fl = {c, r >= 128, (ones % 2) == 0, r == 0};
  endtask

  task automatic alu_op(input int a, input int b, input int op, input int sh, input bit en);
    int res;
    logic [3:0] fl;
    write_reg(0, a);
    write_reg(1, b);
    busb_addr = 3'd1; selop = 3'(op); shamt = 2'(sh);
    enaf = en; mdr_alu_n = 1'b0; mdr_en = 1'b1;
    tick();
    enaf = 1'b0; mdr_en = 1'b0; mdr_alu_n = 1'b1;
    ref_alu(a, b, op, sh, res, fl);
    if (en) model_flags = fl;
    check($sformatf("alu_res op%0d", op), 32'(mem_wdata), 32'(res));
    check($sformatf("alu_flags op%0d", op), 32'(flags), 32'(model_flags));
  endtask

  // Runs an in-flight transfer to completion; ack raised during busy cycle ack_at (0 = never).
  task automatic run_xfer(input int ack_at, output int busy_cyc, output int done_cnt,
                          output int we_cnt);
    busy_cyc = 0; done_cnt = 0; we_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      if (done) begin
        done_cnt++;
        break;
      end
      if (busy) busy_cyc++;
      if (mem_we) we_cnt++;
      mem_ack = busy && (busy_cyc == ack_at);
      tick();
    end
    mem_ack = 1'b0;
    mdr_en = 1'b0;
    tick();
    if (done) done_cnt++;
  endtask

  initial begin
    int bc, dc, wc;
    int a, b, op, sh;

    // reset state
    #3;
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_bus_err", 32'(bus_err), 0);
    check("rst_flags", 32'(flags), 0);
    check("rst_out_ir", 32'(out_ir), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // directed ADD with carry out
    alu_op(8'hF0, 8'h20, 0, 0, 1'b1);
    check("add_f0_20_res", 32'(mem_wdata), 32'h10);
    check("add_f0_20_flags", 32'(flags), 32'h8);

    // flags hold when enaf is low
    alu_op(8'h00, 8'h00, 2, 0, 1'b0);

    // shift boundaries
    alu_op(8'h81, 8'h00, 6, 0, 1'b1);
    alu_op(8'h81, 8'h00, 6, 1, 1'b1);
    alu_op(8'h81, 8'h00, 7, 1, 1'b1);
    alu_op(8'h40, 8'h00, 6, 3, 1'b1);
    alu_op(8'h05, 8'h07, 1, 0, 1'b1);

    // randomized ALU sweep
    for (int i = 0; i < 24; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      op = $urandom_range(0, 7);
      sh = $urandom_range(0, 3);
      alu_op(a, b, op, sh, ($urandom_range(0, 3) != 0));
    end

    // IR load, then sclr over ir_en
    load_mdr(8'hB8);
    ir_en = 1'b1; tick(); ir_en = 1'b0;
    check("ir_load", 32'(out_ir), 32'h17);
    sclr = 1'b1; ir_en = 1'b1; tick(); sclr = 1'b0; ir_en = 1'b0;
    check("ir_sclr_prio", 32'(out_ir), 0);

    // memory write
    load_mdr(8'h12);
    mar_en = 1'b1; tick(); mar_en = 1'b0;
    load_mdr(8'h3C);
    wr_start = 1'b1; tick(); wr_start = 1'b0;
    check("wr_mem_req", 32'(mem_req), 1);
    check("wr_mem_we", 32'(mem_we), 1);
    check("wr_mem_addr", 32'(mem_addr), 32'h12);
    check("wr_mem_wdata", 32'(mem_wdata), 32'h3C);
    run_xfer(3, bc, dc, wc);
    check("wr_busy_cycles", 32'(bc), 3);
    check("wr_we_cycles", 32'(wc), 3);
    check("wr_done_count", 32'(dc), 1);
    check("wr_we_after", 32'(mem_we), 0);

    // memory read, ack during fourth wait cycle
    mem_rdata = 8'hA5;
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    check("rd_mem_req", 32'(mem_req), 1);
    check("rd_mem_we", 32'(mem_we), 0);
    run_xfer(4, bc, dc, wc);
    check("rd_busy_cycles", 32'(bc), 4);
    check("rd_done_count", 32'(dc), 1);
    check("rd_mdr", 32'(mem_wdata), 32'hA5);
    check("rd_bus_err", 32'(bus_err), 0);

    // timeout, with mdr_en asserted while busy (must be ignored)
    load_mdr(8'h3C);
    mem_rdata = 8'hFF;
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    mdr_en = 1'b1; mdr_alu_n = 1'b1;
    run_xfer(0, bc, dc, wc);
    check("to_busy_cycles", 32'(bc), 15);
    check("to_done_count", 32'(dc), 1);
    check("to_bus_err", 32'(bus_err), 1);
    check("to_mdr_kept", 32'(mem_wdata), 32'h3C);

    // next accepted start clears bus_err
    wr_start = 1'b1; tick(); wr_start = 1'b0;
    check("err_clear", 32'(bus_err), 0);
    check("err_clear_busy", 32'(busy), 1);
    run_xfer(1, bc, dc, wc);
    check("err_clear_done", 32'(dc), 1);

    // ack on the timeout edge wins
    mem_rdata = 8'h66;
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    run_xfer(15, bc, dc, wc);
    check("ack_at_to_busy", 32'(bc), 15);
    check("ack_at_to_err", 32'(bus_err), 0);
    check("ack_at_to_mdr", 32'(mem_wdata), 32'h66);

    // simultaneous starts: read only
    mem_rdata = 8'h5A;
    rd_start = 1'b1; wr_start = 1'b1; tick(); rd_start = 1'b0; wr_start = 1'b0;
    check("both_we", 32'(mem_we), 0);
    run_xfer(2, bc, dc, wc);
    check("both_we_cycles", 32'(wc), 0);
    check("both_mdr", 32'(mem_wdata), 32'h5A);

    // ack in IDLE is ignored
    mem_ack = 1'b1; tick(); tick(); mem_ack = 1'b0;
    check("idle_ack_busy", 32'(busy), 0);
    check("idle_ack_done", 32'(done), 0);

    // reset mid-RD_WAIT; register bank survives
    write_reg(0, 8'h11);
    write_reg(2, 8'h22);
    load_mdr(8'hB8);
    ir_en = 1'b1; mar_en = 1'b1; tick(); ir_en = 1'b0; mar_en = 1'b0;
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    tick();
    check("mid_busy_before", 32'(mem_req), 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_mem_req", 32'(mem_req), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ir", 32'(out_ir), 0);
    check("mid_rst_mar", 32'(mem_addr), 0);
    check("mid_rst_mdr", 32'(mem_wdata), 0);
    check("mid_rst_flags", 32'(flags), 0);
    mem_ack = 1'b1; tick(); tick(); mem_ack = 1'b0;
    check("mid_rst_no_done", 32'(done), 0);
    #2 rst = 1'b1;
    tick();
    check("post_rst_done", 32'(done), 0);
    busb_addr = 3'd2; selop = 3'd0; mdr_alu_n = 1'b0; mdr_en = 1'b1;
    tick();
    mdr_en = 1'b0; mdr_alu_n = 1'b1;
    check("bank_survives_rst", 32'(mem_wdata), 32'h33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
